// File: rtl/alu_serial_shifter.sv
// ============================================================================
// Module  : alu_serial_shifter
// Brief   : Bit-serial SLL/SRL/SRA unit with valid/ready handshakes.
//           Optional rotate-right on op 11 when SHIFTER_ROR_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial_shifter #(
    parameter int DATA_W = 32,
    parameter int SA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SA_W-1:0]   sa_in,
    input  logic              flush_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0]      OP_SLL   = 2'b00;
    localparam logic [1:0]      OP_SRL   = 2'b01;
    localparam logic [1:0]      OP_SRA   = 2'b10;
    localparam logic [1:0]      OP_ROR   = 2'b11;
    localparam logic [SA_W-1:0] CNT_ONE  = SA_W'(1);
    localparam logic [SA_W-1:0] CNT_ZERO = '0;

    state_t            state;
    state_t            state_next;
    logic [SA_W-1:0]   count;
    logic [SA_W-1:0]   count_next;
    logic [1:0]        op;
    logic [1:0]        op_next;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] work_next;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] result_next;
    logic [DATA_W-1:0] step;

    // One-bit shift of the working register for the latched operation.
    always_comb begin
        step = {1'b0, work[DATA_W-1:1]};
        case (op)
            OP_SLL: step = {work[DATA_W-2:0], 1'b0};
            OP_SRL: step = {1'b0, work[DATA_W-1:1]};
            OP_SRA: step = {work[DATA_W-1], work[DATA_W-1:1]};
            OP_ROR: begin
`ifdef SHIFTER_ROR_EN
                step = {work[0], work[DATA_W-1:1]};
`else
                step = {1'b0, work[DATA_W-1:1]};
`endif
            end
            default: step = {1'b0, work[DATA_W-1:1]};
        endcase
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        op_next     = op;
        work_next   = work;
        result_next = result;

        if (flush_in) begin
            // Abort wins over everything; the last delivered result stays visible.
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_next    = op_in;
                        work_next  = data_in;
                        count_next = sa_in;
                        if (sa_in == CNT_ZERO) begin
                            state_next  = DONE;
                            result_next = data_in;
                        end else begin
                            state_next = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_next  = step;
                    count_next = count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state_next  = DONE;
                        result_next = step;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            op     <= OP_SLL;
            work   <= '0;
            result <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            op     <= op_next;
            work   <= work_next;
            result <= result_next;
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign result_out = result;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_shifter.sv
// ============================================================================
// Module  : tb_alu_serial_shifter
// Brief   : Directed self-checking bench for alu_serial_shifter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_serial_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_in;
    logic [31:0] data_in;
    logic [4:0]  sa_in;
    logic        flush_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_out;

    int errors = 0;
    int checks = 0;
    int lat;
    bit seen_valid;

    alu_serial_shifter #(.DATA_W(32), .SA_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_in      (op_in),
        .data_in    (data_in),
        .sa_in      (sa_in),
        .flush_in   (flush_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; request is taken at the following posedge.
    task automatic accept(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sa);
        op_in    = op;
        data_in  = d;
        sa_in    = sa;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is seen (cycle 1 = first negedge).
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sa, input logic [31:0] exp);
        int n;
        out_ready = 1'b1;
        @(negedge clk);
        accept(op, d, sa);
        wait_valid(n);
        chk({tag, "_lat"}, 32'(n), 32'(sa) + 32'd1);
        chk({tag, "_res"}, result_out, exp);
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_in     = 2'b00;
        data_in   = '0;
        sa_in     = '0;
        flush_in  = 1'b0;
        out_ready = 1'b0;

        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
        run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run_op("sra0", 2'b10, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        @(negedge clk);
        accept(2'b00, 32'h0000_00F0, 5'd3);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", result_out, 32'h0000_0780);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        // Release and present the next request at once; it is taken a cycle later.
        out_ready = 1'b1;
        op_in     = 2'b01;
        data_in   = 32'h0000_0100;
        sa_in     = 5'd8;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("b2b_idle", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("b2b_lat", 32'(lat), 32'd9);
        chk("b2b_res", result_out, 32'h0000_0001);
        @(negedge clk);

        // Flush at cycle 5 of a 20-step shift with a coincident request.
        accept(2'b01, 32'hFFFF_FFFF, 5'd20);
        repeat (5) @(negedge clk);
        flush_in  = 1'b1;
        in_valid  = 1'b1;
        op_in     = 2'b00;
        sa_in     = 5'd2;
        @(negedge clk);
        flush_in = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle", {30'd0, in_ready, out_valid}, 32'd2);
        chk("flush_result_kept", result_out, 32'h0000_0001);
        seen_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("flush_no_valid", {31'd0, seen_valid}, 32'd0);

        // Asynchronous reset in the middle of a shift.
        accept(2'b00, 32'h0000_0001, 5'd20);
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_idle", {30'd0, in_ready, out_valid}, 32'd2);
        chk("arst_result", result_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SHIFTER_ROR_EN
        run_op("op11", 2'b11, 32'h0000_0003, 5'd1, 32'h8000_0001);
`else
        run_op("op11", 2'b11, 32'h0000_0003, 5'd1, 32'h0000_0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
